// File: rtl/bus_master_arbiter_pkg.sv
// Shared system-bus definitions: strobe/grant polarities, direction codes,
// channel count, owner index width and word widths.
// Latency: n/a (constants and types only). Backpressure: n/a.
package bus_master_arbiter_pkg;

  // Active-low control encodings used on every bus strobe/grant/request.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Direction on mN_rw / s_rw.
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam int BUS_MASTER_CH = 4;
  localparam int BUS_OWNER_W   = 2;
  localparam int WORD_ADDR_W   = 30;
  localparam int WORD_DATA_W   = 32;

  typedef logic [BUS_OWNER_W-1:0]   owner_t;
  typedef logic [BUS_MASTER_CH-1:0] req_vec_t;

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Master-side channels plus the common slave-side bus of the arbiter.
// Latency: n/a (wires only). Backpressure: s_rdy_ from the slave-side mux.
// Ports: per-master req_/addr/as_/rw/wr_data in, grnt_ out; s_rdy_ in, s_* out.
interface bus_master_arbiter_if #(
  parameter int NUM_MASTERS = bus_master_arbiter_pkg::BUS_MASTER_CH,
  parameter int ADDR_W      = bus_master_arbiter_pkg::WORD_ADDR_W,
  parameter int DATA_W      = bus_master_arbiter_pkg::WORD_DATA_W
);
  import bus_master_arbiter_pkg::*;

  // Master channels, bit/element N belongs to master N. All control active-low.
  logic [NUM_MASTERS-1:0] req_;
  logic [ADDR_W-1:0]      addr    [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] as_;
  logic [NUM_MASTERS-1:0] rw;
  logic [DATA_W-1:0]      wr_data [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] grnt_;

  // Common slave-side bus.
  logic              s_rdy_;
  logic [ADDR_W-1:0] s_addr;
  logic              s_as_;
  logic              s_rw;
  logic [DATA_W-1:0] s_wr_data;

  // Arbiter view: consumes master requests, drives grants and the shared bus.
  modport slave (
    input  req_, addr, as_, rw, wr_data, s_rdy_,
    output grnt_, s_addr, s_as_, s_rw, s_wr_data
  );

  // Requester/environment view.
  modport master (
    output req_, addr, as_, rw, wr_data, s_rdy_,
    input  grnt_, s_addr, s_as_, s_rw, s_wr_data
  );

endinterface

// File: rtl/bus_rr_pick.sv
// Rotating-priority picker: first active request after the current owner.
// Latency: combinational. Backpressure: n/a.
// Ports: req (active-high vector), owner in; next_owner, found out.
module bus_rr_pick
  import bus_master_arbiter_pkg::*;
(
  input  req_vec_t req,
  input  owner_t   owner,
  output owner_t   next_owner,
  output logic     found
);

  owner_t cand;

  // The owner itself is never a candidate; found=0 means nobody else wants
  // the bus. Scanning from the farthest offset down lets the nearest
  // requester (owner+1 first) overwrite the result last.
  always_comb begin
    next_owner = owner;
    found      = 1'b0;
    cand       = owner;
    for (int i = BUS_MASTER_CH - 1; i >= 1; i--) begin
      cand = owner + owner_t'(i);
      if (req[cand]) begin
        next_owner = cand;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin bus arbiter with owner parking and master-to-slave bus mux.
// Latency: grant changes at the edge that samples the release, visible next cycle; mux follows grant.
// Backpressure: an open transfer (strobe without s_rdy_) freezes ownership until s_rdy_ completes it.
// Ports: clk, reset (sync, active-high); bus = slave modport of bus_master_arbiter_if.
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_master_arbiter_if.slave  bus
);

  localparam int HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  owner_t            owner;
  logic              busy;
  logic [HOLD_W-1:0] hold_cnt;
  req_vec_t          grnt_q;

  req_vec_t req_vec;
  owner_t   pick;
  logic     pick_found;
  logic     sel_as;
  logic     owner_req;
  logic     strobe_open;
  logic     hold_full;
  logic     do_handover;
  logic     do_preempt;
  logic     move;

  assign req_vec = ~bus.req_;

  bus_rr_pick u_pick (
    .req        (req_vec),
    .owner      (owner),
    .next_owner (pick),
    .found      (pick_found)
  );

  // Mux is not gated by req_: an idle granted master keeps its strobe high.
  assign sel_as        = bus.as_[owner];
  assign bus.s_addr    = bus.addr[owner];
  assign bus.s_as_     = sel_as;
  assign bus.s_rw      = bus.rw[owner];
  assign bus.s_wr_data = bus.wr_data[owner];
  assign bus.grnt_     = grnt_q;

  assign owner_req = req_vec[owner];

  // A strobe that is not completed this cycle opens a transfer; it must
  // block handover at this same edge even though busy is not yet set.
  assign strobe_open = (sel_as == ENABLE_) && (bus.s_rdy_ == DISABLE_);

  assign hold_full = (HOLD_MAX > 0) && (hold_cnt == HOLD_LIM);

  // pick_found already implies another master is requesting.
  assign do_handover = !busy && !strobe_open && !owner_req && pick_found;
  assign do_preempt  = hold_full && !busy && (sel_as == DISABLE_) && pick_found;
  assign move        = do_handover || do_preempt;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      grnt_q   <= {DISABLE_, DISABLE_, DISABLE_, ENABLE_};
    end else begin
      if (move) begin
        owner  <= pick;
        grnt_q <= ~(req_vec_t'(1) << pick);
      end

      // Completion wins over a new strobe: zero-wait accesses never set busy.
      if (bus.s_rdy_ == ENABLE_) begin
        busy <= 1'b0;
      end else if (sel_as == ENABLE_) begin
        busy <= 1'b1;
      end

      // Tenure counter only runs while the owner is contended.
      if (move || !pick_found) begin
        hold_cnt <= '0;
      end else if (owner_req && (hold_cnt != HOLD_LIM)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed and random stimulus for two arbiters (hold limit 4 and disabled)
// driven with identical inputs and compared against a behavioural model.
module tb_bus_master_arbiter;
  import bus_master_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_master_arbiter_if bus_a ();
  bus_master_arbiter_if bus_b ();

  bus_master_arbiter #(.HOLD_MAX(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  bus_master_arbiter #(.HOLD_MAX(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Stimulus state shared by both DUTs.
  logic [3:0]  t_req_;
  logic [3:0]  t_as_;
  logic [3:0]  t_rw;
  logic        t_rdy_;
  logic        t_reset;
  logic [29:0] t_addr [4];
  logic [31:0] t_wr   [4];

  // Reference model state per DUT (0: hold limit 4, 1: no pre-emption).
  int m_owner [2];
  bit m_busy  [2];
  int m_hold  [2];
  int hmax    [2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    reset = t_reset;
    bus_a.req_ = t_req_;  bus_b.req_ = t_req_;
    bus_a.as_  = t_as_;   bus_b.as_  = t_as_;
    bus_a.rw   = t_rw;    bus_b.rw   = t_rw;
    bus_a.s_rdy_ = t_rdy_; bus_b.s_rdy_ = t_rdy_;
    for (int n = 0; n < 4; n++) begin
      bus_a.addr[n] = t_addr[n];  bus_b.addr[n] = t_addr[n];
      bus_a.wr_data[n] = t_wr[n]; bus_b.wr_data[n] = t_wr[n];
    end
  endtask

  function automatic logic [3:0] grant_of(input int k);
    return (k == 0) ? bus_a.grnt_ : bus_b.grnt_;
  endfunction

  // Next state from the arbitration rules, using the inputs present at the edge.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int o;
      int nxt;
      bit others;
      bit wants;
      bit as_lo;
      bit rdy_lo;
      bit open_x;
      bit move;
      o = m_owner[k];
      others = 1'b0;
      nxt = o;
      for (int d = 1; d < 4; d++) begin
        if (!others && t_req_[(o + d) % 4] == 1'b0) begin
          others = 1'b1;
          nxt = (o + d) % 4;
        end
      end
      wants  = (t_req_[o] == 1'b0);
      as_lo  = (t_as_[o] == 1'b0);
      rdy_lo = (t_rdy_ == 1'b0);
      if (t_reset) begin
        m_owner[k] = 0;
        m_busy[k]  = 1'b0;
        m_hold[k]  = 0;
      end else begin
        open_x = m_busy[k] || (as_lo && !rdy_lo);
        move = others && !open_x &&
               (!wants || (hmax[k] > 0 && m_hold[k] == hmax[k] && !as_lo));
        m_busy[k] = rdy_lo ? 1'b0 : (as_lo ? 1'b1 : m_busy[k]);
        if (move || !others) m_hold[k] = 0;
        else if (wants && m_hold[k] < hmax[k]) m_hold[k] = m_hold[k] + 1;
        if (move) m_owner[k] = nxt;
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic [3:0]  eg;
      logic [3:0]  g;
      logic [29:0] a;
      logic        sa;
      logic        sr;
      logic [31:0] wd;
      string       dn;
      int          o;
      o = m_owner[k];
      eg = 4'b1111;
      eg[o] = 1'b0;
      dn = (k == 0) ? "h4" : "h0";
      if (k == 0) begin
        g = bus_a.grnt_; a = bus_a.s_addr; sa = bus_a.s_as_; sr = bus_a.s_rw; wd = bus_a.s_wr_data;
      end else begin
        g = bus_b.grnt_; a = bus_b.s_addr; sa = bus_b.s_as_; sr = bus_b.s_rw; wd = bus_b.s_wr_data;
      end
      chk($sformatf("%s/%s/grnt", tag, dn), 64'(g), 64'(eg));
      chk($sformatf("%s/%s/s_addr", tag, dn), 64'(a), 64'(t_addr[o]));
      chk($sformatf("%s/%s/s_as", tag, dn), 64'(sa), 64'(t_as_[o]));
      chk($sformatf("%s/%s/s_rw", tag, dn), 64'(sr), 64'(t_rw[o]));
      chk($sformatf("%s/%s/s_wr", tag, dn), 64'(wd), 64'(t_wr[o]));
    end
  endtask

  task automatic tick();
    drive(); #1; model_update(); @(posedge clk); #1;
  endtask

  task automatic step(input string tag);
    drive(); #1; check_model(tag); model_update(); @(posedge clk); #1;
  endtask

  task automatic expect_grant(input string tag, input int k, input logic [3:0] exp);
    chk($sformatf("%s/%s", tag, (k == 0) ? "h4" : "h0"), 64'(grant_of(k)), 64'(exp));
  endtask

  initial begin
    hmax[0] = 4; hmax[1] = 0;
    m_owner[0] = 0; m_owner[1] = 0;
    m_busy[0] = 1'b0; m_busy[1] = 1'b0;
    m_hold[0] = 0; m_hold[1] = 0;
    t_req_ = 4'b1111; t_as_ = 4'b1111; t_rdy_ = 1'b1; t_reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      t_addr[n] = 30'h0000_1234 + 30'(n * 'h1000);
      t_wr[n]   = 32'hA5A5_0000 + 32'(n);
      t_rw[n]   = (n % 2 == 1) ? READ : WRITE;
    end

    // Reset for two cycles with nobody requesting.
    tick(); tick();
    t_reset = 1'b0;
    drive(); #1;
    expect_grant("reset_grnt", 0, 4'b1110);
    expect_grant("reset_grnt", 1, 4'b1110);
    chk("reset_s_addr", 64'(bus_a.s_addr), 64'(30'h0000_1234));
    step("idle");

    // Round-robin: m1..m3 requesting, each releases in turn, then m0.
    t_req_ = 4'b0001; step("rr0");
    expect_grant("rr_m1", 0, 4'b1101); expect_grant("rr_m1", 1, 4'b1101);
    t_req_ = 4'b0011; step("rr1");
    expect_grant("rr_m2", 0, 4'b1011); expect_grant("rr_m2", 1, 4'b1011);
    t_req_ = 4'b0111; step("rr2");
    expect_grant("rr_m3", 0, 4'b0111); expect_grant("rr_m3", 1, 4'b0111);
    t_req_ = 4'b1110; step("rr3");
    expect_grant("rr_m0", 0, 4'b1110); expect_grant("rr_m0", 1, 4'b1110);

    // Busy blocks handover: m2 strobes and releases together, m0 waits.
    t_req_ = 4'b1011; step("bz_own");
    expect_grant("bz_m2", 0, 4'b1011);
    t_req_ = 4'b1110; t_as_ = 4'b1011; t_addr[2] = 30'h100;
    drive(); #1;
    chk("bz_s_addr", 64'(bus_a.s_addr), 64'(30'h100));
    step("bz_t0");
    expect_grant("bz_hold0", 0, 4'b1011); expect_grant("bz_hold0", 1, 4'b1011);
    step("bz_t1");
    expect_grant("bz_hold1", 0, 4'b1011);
    step("bz_t2");
    expect_grant("bz_hold2", 0, 4'b1011);
    t_rdy_ = 1'b0; step("bz_rdy");
    expect_grant("bz_hold3", 0, 4'b1011); expect_grant("bz_hold3", 1, 4'b1011);
    t_rdy_ = 1'b1; t_as_ = 4'b1111; step("bz_rel");
    expect_grant("bz_m0", 0, 4'b1110); expect_grant("bz_m0", 1, 4'b1110);

    // Zero-wait access leaves busy clear; release next cycle hands over.
    t_req_ = 4'b1100; t_as_ = 4'b1110; t_rdy_ = 1'b0; step("zw_acc");
    expect_grant("zw_keep", 0, 4'b1110);
    t_req_ = 4'b1101; t_as_ = 4'b1111; t_rdy_ = 1'b1; step("zw_rel");
    expect_grant("zw_m1", 0, 4'b1101); expect_grant("zw_m1", 1, 4'b1101);

    // Pre-emption: m1 hogs with idle strobe, m3 requests.
    t_req_ = 4'b0101;
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("pe%0d", i));
      expect_grant($sformatf("pe_wait%0d", i), 0, 4'b1101);
    end
    step("pe5");
    expect_grant("pe_m3", 0, 4'b0111);
    expect_grant("pe_m1", 1, 4'b1101);
    for (int i = 0; i < 15; i++) step("pe_long");
    expect_grant("pe_nohold", 1, 4'b1101);

    // Reset in the middle of an m3 transfer.
    t_req_ = 4'b0111; step("rm_own");
    expect_grant("rm_m3", 0, 4'b0111); expect_grant("rm_m3", 1, 4'b0111);
    t_as_ = 4'b0111; t_addr[3] = 30'h3C0; step("rm_strobe");
    expect_grant("rm_busy", 1, 4'b0111);
    t_reset = 1'b1; tick();
    m_busy[0] = 1'b0; m_busy[1] = 1'b0;
    t_reset = 1'b0; t_req_ = 4'b1101; t_as_ = 4'b1111;
    drive(); #1;
    expect_grant("rm_reset", 0, 4'b1110); expect_grant("rm_reset", 1, 4'b1110);
    chk("rm_s_addr", 64'(bus_b.s_addr), 64'(t_addr[0]));
    step("rm_req1");
    expect_grant("rm_free", 0, 4'b1101); expect_grant("rm_free", 1, 4'b1101);
    t_req_ = 4'b1111; t_rdy_ = 1'b0; step("rm_stale");
    expect_grant("rm_stale", 0, 4'b1101); expect_grant("rm_stale", 1, 4'b1101);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      t_req_  = 4'($urandom);
      for (int n = 0; n < 4; n++) begin
        t_as_[n]  = ($urandom_range(0, 2) == 0) ? ENABLE_ : DISABLE_;
        t_rw[n]   = 1'($urandom);
        t_addr[n] = 30'($urandom);
        t_wr[n]   = $urandom;
      end
      t_rdy_  = ($urandom_range(0, 2) == 0) ? ENABLE_ : DISABLE_;
      t_reset = ($urandom_range(0, 49) == 0);
      step("rnd");
    end
    t_reset = 1'b0;
    t_req_ = 4'b1111; t_as_ = 4'b1111; t_rdy_ = 1'b1;
    step("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
